// File: rtl/fp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_seq
// Brief    : Multi-cycle sign/exponent/mantissa FP adder-subtractor with
//            shift-per-cycle alignment/normalisation and valid/ready handshakes.
// Revision : 1.0
// ============================================================================
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic             in_s_a,
    input  logic             in_s_b,
    input  logic [EXP_W-1:0] in_exp_a,
    input  logic [EXP_W-1:0] in_exp_b,
    input  logic [MAN_W-1:0] in_man_a,
    input  logic [MAN_W-1:0] in_man_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_s,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_man,
    output logic             out_ovf,
    output logic             out_unf
);

    localparam logic [EXP_W-1:0] c_exp_max  = '1;
    localparam logic [EXP_W-1:0] c_exp_one  = EXP_W'(1);
    localparam logic [MAN_W-1:0] c_man_max  = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ALIGN   = 3'd1,
        S_COMPUTE = 3'd2,
        S_NORM    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_s_a;
    logic               r_s_b;      // effective sign of B (operator folded in)
    logic [EXP_W-1:0]   r_exp_a;
    logic [EXP_W-1:0]   r_exp_b;
    logic [MAN_W-1:0]   r_man_a;
    logic [MAN_W-1:0]   r_man_b;
    logic               r_s_r;
    logic [EXP_W-1:0]   r_exp_r;
    logic [MAN_W-1:0]   r_man_r;
    logic               r_carry;

    logic [MAN_W:0]     w_sum;
    logic               w_same_sign;
    logic               w_a_ge_b;
    logic [MAN_W-1:0]   w_man_c;
    logic               w_carry_c;
    logic               w_sign_c;

    assign in_ready = (r_state == S_IDLE);

    // Mantissa combine for the COMPUTE cycle; the larger magnitude sets the sign.
    always_comb begin
        w_sum       = {1'b0, r_man_a} + {1'b0, r_man_b};
        w_same_sign = (r_s_a == r_s_b);
        w_a_ge_b    = (r_man_a >= r_man_b);
        w_man_c     = '0;
        w_carry_c   = 1'b0;
        w_sign_c    = r_s_a;
        if (w_same_sign) begin
            w_man_c   = w_sum[MAN_W-1:0];
            w_carry_c = w_sum[MAN_W];
        end else if (w_a_ge_b) begin
            w_man_c   = r_man_a - r_man_b;
        end else begin
            w_man_c   = r_man_b - r_man_a;
            w_sign_c  = r_s_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_s_a     <= 1'b0;
            r_s_b     <= 1'b0;
            r_exp_a   <= '0;
            r_exp_b   <= '0;
            r_man_a   <= '0;
            r_man_b   <= '0;
            r_s_r     <= 1'b0;
            r_exp_r   <= '0;
            r_man_r   <= '0;
            r_carry   <= 1'b0;
            out_valid <= 1'b0;
            out_s     <= 1'b0;
            out_exp   <= '0;
            out_man   <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_s_a   <= in_s_a;
                        r_s_b   <= in_s_b ^ in_op;
                        r_exp_a <= in_exp_a;
                        r_exp_b <= in_exp_b;
                        r_man_a <= in_man_a;
                        r_man_b <= in_man_b;
                        r_state <= S_ALIGN;
                    end
                end

                // One alignment shift per cycle; a shifted-out operand becomes
                // zero and the other operand is passed through untouched.
                S_ALIGN: begin
                    if (r_man_a == '0) begin
                        out_s     <= r_s_b;
                        out_exp   <= r_exp_b;
                        out_man   <= r_man_b;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_man_b == '0) begin
                        out_s     <= r_s_a;
                        out_exp   <= r_exp_a;
                        out_man   <= r_man_a;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_exp_a < r_exp_b) begin
                        r_man_a   <= r_man_a >> 1;
                        r_exp_a   <= r_exp_a + c_exp_one;
                    end else if (r_exp_a > r_exp_b) begin
                        r_man_b   <= r_man_b >> 1;
                        r_exp_b   <= r_exp_b + c_exp_one;
                    end else begin
                        r_state   <= S_COMPUTE;
                    end
                end

                S_COMPUTE: begin
                    r_exp_r <= r_exp_a;
                    r_man_r <= w_man_c;
                    r_carry <= w_carry_c;
                    r_s_r   <= w_sign_c;
                    if (w_man_c == '0 && !w_carry_c) begin
                        out_s     <= 1'b0;
                        out_exp   <= '0;
                        out_man   <= '0;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_state   <= S_NORM;
                    end
                end

                S_NORM: begin
                    if (r_carry && r_exp_r == c_exp_max) begin
                        out_s     <= r_s_r;
                        out_exp   <= c_exp_max;
                        out_man   <= c_man_max;
                        out_ovf   <= 1'b1;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_carry) begin
                        r_man_r   <= {1'b1, r_man_r[MAN_W-1:1]};
                        r_exp_r   <= r_exp_r + c_exp_one;
                        r_carry   <= 1'b0;
                    end else if (!r_man_r[MAN_W-1] && r_exp_r == '0) begin
                        out_s     <= 1'b0;
                        out_exp   <= '0;
                        out_man   <= '0;
                        out_unf   <= 1'b1;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (!r_man_r[MAN_W-1]) begin
                        r_man_r   <= {r_man_r[MAN_W-2:0], 1'b0};
                        r_exp_r   <= r_exp_r - c_exp_one;
                    end else begin
                        out_s     <= r_s_r;
                        out_exp   <= r_exp_r;
                        out_man   <= r_man_r;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_ovf   <= 1'b0;
                        out_unf   <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_seq
// Brief    : Directed and random checks of fp_addsub_seq against a value model.
// Revision : 1.0
// ============================================================================
module tb_fp_addsub_seq;

    localparam int EXP_W = 8;
    localparam int MAN_W = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic             in_s_a;
    logic             in_s_b;
    logic [EXP_W-1:0] in_exp_a;
    logic [EXP_W-1:0] in_exp_b;
    logic [MAN_W-1:0] in_man_a;
    logic [MAN_W-1:0] in_man_b;
    logic             out_valid;
    logic             out_ready;
    logic             out_s;
    logic [EXP_W-1:0] out_exp;
    logic [MAN_W-1:0] out_man;
    logic             out_ovf;
    logic             out_unf;

    int n_checks = 0;
    int n_errors = 0;

    fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_s_a(in_s_a), .in_s_b(in_s_b),
        .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
        .in_man_a(in_man_a), .in_man_b(in_man_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_exp(out_exp), .out_man(out_man),
        .out_ovf(out_ovf), .out_unf(out_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Value/latency model: align in one step, add, then normalise by count.
    function automatic void model(
        input  logic op, input logic sa, input int ea, input longint ma,
        input  logic sb, input int eb, input longint mb,
        output logic rs, output int re, output longint rm,
        output logic ro, output logic ru, output int lat);
        logic   sbe;
        int     diff, e, d, lz, top;
        longint sum, x, a, b;
        sbe = sb ^ op;
        ro = 1'b0; ru = 1'b0;
        diff = (ea > eb) ? ea - eb : eb - ea;
        if (ma == 0) begin rs = sbe; re = eb; rm = mb; lat = 1; return; end
        if (mb == 0) begin rs = sa;  re = ea; rm = ma; lat = 1; return; end
        if (diff >= MAN_W) begin
            lat = 1 + MAN_W;
            if (ea < eb) begin rs = sbe; re = eb; rm = mb; end
            else         begin rs = sa;  re = ea; rm = ma; end
            return;
        end
        a = ma; b = mb; d = diff;
        if (ea < eb) begin a = ma >> diff; e = eb; end
        else         begin b = mb >> diff; e = ea; end
        if (sa == sbe)   begin sum = a + b; rs = sa;  end
        else if (a >= b) begin sum = a - b; rs = sa;  end
        else             begin sum = b - a; rs = sbe; end
        if (sum == 0) begin rs = 1'b0; re = 0; rm = 0; lat = d + 2; return; end
        if (sum >= (longint'(1) << MAN_W)) begin
            if (e == (1 << EXP_W) - 1) begin
                ro = 1'b1; re = e; rm = (longint'(1) << MAN_W) - 1; lat = d + 3;
            end else begin
                re = e + 1; rm = sum >> 1; lat = d + 4;
            end
            return;
        end
        top = 0;
        x = sum;
        while (x > 1) begin x = x >> 1; top++; end
        lz = (MAN_W - 1) - top;
        if (lz > e) begin
            ru = 1'b1; rs = 1'b0; re = 0; rm = 0; lat = d + e + 3;
        end else begin
            re = e - lz; rm = sum << lz; lat = d + lz + 3;
        end
    endfunction

    task automatic scramble_inputs();
        in_op    = 1'($urandom);
        in_s_a   = 1'($urandom);
        in_s_b   = 1'($urandom);
        in_exp_a = EXP_W'($urandom);
        in_exp_b = EXP_W'($urandom);
        in_man_a = MAN_W'($urandom);
        in_man_b = MAN_W'($urandom);
    endtask

    // mode: 0 plain, 1 hold out_ready low 10 cycles, 2 drive in_valid while busy,
    //       3 out_ready already high before out_valid
    task automatic run_op(
        input string tag, input int mode,
        input logic op, input logic sa, input int ea, input longint ma,
        input logic sb, input int eb, input longint mb,
        input logic ws, input int we, input longint wm,
        input logic wo, input logic wu, input int wlat);
        int   lat;
        logic seen, busy_ok, stable;
        check({tag, "/idle_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_op = op; in_s_a = sa; in_s_b = sb;
        in_exp_a = EXP_W'(ea); in_exp_b = EXP_W'(eb);
        in_man_a = MAN_W'(ma); in_man_b = MAN_W'(mb);
        in_valid  = 1'b1;
        out_ready = (mode == 3);
        @(posedge clk); #1;
        if (mode == 2) scramble_inputs();
        else           in_valid = 1'b0;
        lat = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && lat < 200) begin
            @(posedge clk); lat++; #1;
            if (out_valid) seen = 1'b1;
            else if (in_ready) busy_ok = 1'b0;
            if (mode == 2 && !seen) scramble_inputs();
        end
        in_valid = 1'b0;
        check({tag, "/valid_seen"}, 64'(seen), 64'd1);
        check({tag, "/latency"}, 64'(lat), 64'(wlat));
        check({tag, "/result"}, 64'({out_s, out_exp, out_man}),
              64'({ws, EXP_W'(we), MAN_W'(wm)}));
        check({tag, "/flags"}, 64'({out_ovf, out_unf}), 64'({wo, wu}));
        if (mode == 2) check({tag, "/busy_no_accept"}, 64'(busy_ok), 64'd1);
        if (mode == 3) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, "/early_consume"}, 64'({out_valid, in_ready}), 64'b01);
            return;
        end
        check({tag, "/busy_ready"}, 64'(in_ready), 64'd0);
        if (mode == 1) begin
            stable = 1'b1;
            repeat (10) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                    {out_s, out_exp, out_man, out_ovf, out_unf} !==
                    {ws, EXP_W'(we), MAN_W'(wm), wo, wu})
                    stable = 1'b0;
            end
            check({tag, "/hold_stable"}, 64'(stable), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "/exit"}, 64'({out_valid, in_ready, out_ovf, out_unf}), 64'b0100);
    endtask

    task automatic run_model(input string tag, input int mode,
                             input logic op, input logic sa, input int ea, input longint ma,
                             input logic sb, input int eb, input longint mb);
        logic rs, ro, ru;
        int re, lat;
        longint rm;
        model(op, sa, ea, ma, sb, eb, mb, rs, re, rm, ro, ru, lat);
        run_op(tag, mode, op, sa, ea, ma, sb, eb, mb, rs, re, rm, ro, ru, lat);
    endtask

    function automatic longint rand_man();
        if ($urandom_range(0, 9) == 0) return 0;
        return (longint'(1) << (MAN_W - 1)) | longint'($urandom_range(0, (1 << (MAN_W - 1)) - 1));
    endfunction

    initial begin
        int     ea, eb, mode;
        longint ma, mb;
        logic   ok;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        scramble_inputs();
        #1;
        check("reset_outputs", 64'({out_valid, out_s, out_exp, out_man, out_ovf, out_unf}), 64'd0);
        check("reset_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run_op("one_plus_one", 0, 0, 0, 127, 64'h800000, 0, 127, 64'h800000, 0, 128, 64'h800000, 0, 0, 4);
        run_op("three_plus_half", 0, 0, 0, 128, 64'hC00000, 0, 126, 64'h800000, 0, 128, 64'hE00000, 0, 0, 5);
        run_op("one_minus_one", 0, 1, 0, 127, 64'h800000, 0, 127, 64'h800000, 0, 0, 0, 0, 0, 2);
        run_op("cancel", 0, 0, 0, 127, 64'h800000, 1, 127, 64'hC00000, 1, 126, 64'h800000, 0, 0, 4);
        run_op("large_gap", 0, 0, 0, 127, 64'h800000, 0, 97, 64'h800000, 0, 127, 64'h800000, 0, 0, 25);
        run_op("zero_a", 0, 1, 0, 0, 0, 1, 130, 64'hA00000, 0, 130, 64'hA00000, 0, 0, 1);
        run_op("overflow", 0, 0, 0, 255, 64'hFFFFFF, 0, 255, 64'hFFFFFF, 0, 255, 64'hFFFFFF, 1, 0, 3);
        run_op("underflow", 0, 1, 0, 0, 64'hC00000, 0, 0, 64'h800000, 0, 0, 0, 0, 1, 3);
        run_op("both_zero", 0, 1, 0, 40, 0, 0, 90, 0, 1, 90, 0, 0, 0, 1);
        run_op("hold", 1, 0, 0, 128, 64'hC00000, 0, 126, 64'h800000, 0, 128, 64'hE00000, 0, 0, 5);
        run_op("busy_drive", 2, 0, 0, 127, 64'h800000, 1, 127, 64'hC00000, 1, 126, 64'h800000, 0, 0, 4);
        run_op("early_ready", 3, 0, 0, 127, 64'h800000, 0, 127, 64'h800000, 0, 128, 64'h800000, 0, 0, 4);
        run_op("after_early", 0, 0, 0, 128, 64'hC00000, 0, 126, 64'h800000, 0, 128, 64'hE00000, 0, 0, 5);

        // Reset in the middle of a long alignment.
        @(negedge clk);
        in_op = 0; in_s_a = 0; in_s_b = 0;
        in_exp_a = 8'd127; in_exp_b = 8'd97;
        in_man_a = 24'h800000; in_man_b = 24'h800000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midreset_outputs", 64'({out_valid, out_s, out_exp, out_man, out_ovf, out_unf}), 64'd0);
        check("midreset_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        ok = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) ok = 1'b0;
        end
        check("midreset_no_output", 64'(ok), 64'd1);
        run_op("after_reset", 0, 0, 0, 127, 64'h800000, 0, 127, 64'h800000, 0, 128, 64'h800000, 0, 0, 4);

        for (int i = 0; i < 60; i++) begin
            ea = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) begin
                eb = ea + $urandom_range(0, 8) - 4;
                if (eb < 0) eb = 0;
                if (eb > 255) eb = 255;
            end else begin
                eb = $urandom_range(0, 255);
            end
            if ($urandom_range(0, 15) == 0) begin ea = 255; eb = 255; end
            ma = rand_man();
            mb = ($urandom_range(0, 4) == 0) ? ma : rand_man();
            mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_model($sformatf("rand%0d", i), mode, 1'($urandom), 1'($urandom), ea, ma,
                      1'($urandom), eb, mb);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
